// File: rtl/axi_pkg.sv
// Shared AXI definitions: master FSM states, protocol constants and the
// registered command payload used by axi_simple_master.
package axi_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;
    localparam int unsigned SIZE_W = 3;
    localparam int unsigned LEN_W  = 8;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        RSP   = 3'd5
    } state_t;

    // Command payload held for the lifetime of one transaction.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

endpackage

// File: rtl/axi_simple_master.sv
// Single-beat AXI master: turns one command into one AXI read or write and
// returns a single response. At most one transaction is in flight.
module axi_simple_master
    import axi_pkg::*;
#(
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned TXN_ID   = 0
) (
    input  logic                clk,
    input  logic                rst,
    // command
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [SIZE_W-1:0]   i_req_size,
    input  logic [DATA_W-1:0]   i_req_wdata,
    input  logic [STRB_W-1:0]   i_req_wstrb,
    // response
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_err,
    // AW
    output logic [ID_WIDTH-1:0] o_awid,
    output logic [ADDR_W-1:0]   o_awaddr,
    output logic [LEN_W-1:0]    o_awlen,
    output logic [SIZE_W-1:0]   o_awsize,
    output logic [1:0]          o_awburst,
    output logic                o_awvalid,
    input  logic                i_awready,
    // W
    output logic [DATA_W-1:0]   o_wdata,
    output logic [STRB_W-1:0]   o_wstrb,
    output logic                o_wlast,
    output logic                o_wvalid,
    input  logic                i_wready,
    // B
    input  logic [ID_WIDTH-1:0] i_bid,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready,
    // AR
    output logic [ID_WIDTH-1:0] o_arid,
    output logic [ADDR_W-1:0]   o_araddr,
    output logic [LEN_W-1:0]    o_arlen,
    output logic [SIZE_W-1:0]   o_arsize,
    output logic [1:0]          o_arburst,
    output logic                o_arvalid,
    input  logic                i_arready,
    // R
    input  logic [ID_WIDTH-1:0] i_rid,
    input  logic [DATA_W-1:0]   i_rdata,
    input  logic [1:0]          i_rresp,
    input  logic                i_rlast,
    input  logic                i_rvalid,
    output logic                o_rready
);

    localparam logic [ID_WIDTH-1:0] ID = ID_WIDTH'(TXN_ID);

    state_t            state_q, state_d;
    req_t              req_q, req_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              req_ready_q, req_ready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic              bready_q, bready_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic accept;
    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic b_hs;
    logic r_hs;

    assign accept = req_ready_q & i_req_valid;
    assign aw_hs  = awvalid_q & i_awready;
    assign w_hs   = wvalid_q & i_wready;
    assign ar_hs  = arvalid_q & i_arready;
    assign b_hs   = bready_q & i_bvalid;
    assign r_hs   = rready_q & i_rvalid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; WADDR waits until both AW and W have handshaked.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = i_req_we ? WADDR : RADDR;
            WADDR:   if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = WRESP;
            WRESP:   if (b_hs) state_d = RSP;
            RADDR:   if (ar_hs) state_d = RDATA;
            RDATA:   if (r_hs) state_d = RSP;
            RSP:     if (i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of all registered outputs, derived from the next state.
    always_comb begin
        aw_done_d   = 1'b0;
        w_done_d    = 1'b0;
        req_d       = req_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        if (state_q == WADDR) begin
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
        end

        req_ready_d = (state_d == IDLE);
        awvalid_d   = (state_d == WADDR) & ~aw_done_d;
        wvalid_d    = (state_d == WADDR) & ~w_done_d;
        bready_d    = (state_d == WRESP);
        arvalid_d   = (state_d == RADDR);
        rready_d    = (state_d == RDATA);
        rsp_valid_d = (state_d == RSP);

        if (accept) begin
            req_d.addr  = i_req_addr;
            req_d.size  = i_req_size;
            req_d.wdata = i_req_wdata;
            req_d.wstrb = i_req_wstrb;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
        end

        if (state_q == WRESP && b_hs) begin
            rsp_err_d = (|(i_bresp & RESP_SLVERR)) | (i_bid != ID);
        end

        if (state_q == RDATA && r_hs) begin
            rsp_rdata_d = i_rdata;
            rsp_err_d   = (|(i_rresp & RESP_SLVERR)) | (i_rid != ID) | ~i_rlast;
        end
    end

    // Output and payload registers; reset leaves the block ready and quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            req_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            req_q       <= req_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            req_ready_q <= req_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_rsp_rdata = rsp_rdata_q;

    assign o_awid    = ID;
    assign o_awaddr  = req_q.addr;
    assign o_awlen   = '0;
    assign o_awsize  = req_q.size;
    assign o_awburst = BURST_INCR;
    assign o_awvalid = awvalid_q;

    assign o_wdata  = req_q.wdata;
    assign o_wstrb  = req_q.wstrb;
    assign o_wlast  = 1'b1;
    assign o_wvalid = wvalid_q;

    assign o_bready = bready_q;

    assign o_arid    = ID;
    assign o_araddr  = req_q.addr;
    assign o_arlen   = '0;
    assign o_arsize  = req_q.size;
    assign o_arburst = BURST_INCR;
    assign o_arvalid = arvalid_q;

    assign o_rready = rready_q;

endmodule

// File: doc/axi_simple_master.md
AXI_SIMPLE_MASTER -- requirements
Module: axi_simple_master

Interface
REQ-001 Parameter ID_WIDTH, default 4: width of the AXI ID fields; matches the intercon initiator port.
REQ-002 Parameter TXN_ID, default 0: constant ID driven on o_awid and o_arid.
REQ-003 clk  in  1  single clock; all logic is clocked on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 i_req_valid  in  1  command valid.
REQ-006 o_req_ready  out  1  command accepted when high together with i_req_valid.
REQ-007 i_req_we  in  1  1 = write, 0 = read.
REQ-008 i_req_addr  in  32  byte address.
REQ-009 i_req_size  in  3  AXI size code; legal values are 0 to 3.
REQ-010 i_req_wdata, i_req_wstrb  in  64/8  write data and byte strobes.
REQ-011 o_rsp_valid  out  1  response valid.
REQ-012 i_rsp_ready  in  1  response consumed.
REQ-013 o_rsp_rdata  out  64  read data; 0 for writes.
REQ-014 o_rsp_err  out  1  1 = SLVERR/DECERR or ID mismatch.
REQ-015 AW channel: o_awid [ID_WIDTH], o_awaddr [32], o_awlen [8], o_awsize [3], o_awburst [2] and o_awvalid are outputs; i_awready is an input.
REQ-016 W channel: o_wdata [64], o_wstrb [8], o_wlast and o_wvalid are outputs; i_wready is an input.
REQ-017 B channel: i_bid [ID_WIDTH], i_bresp [2] and i_bvalid are inputs; o_bready is an output.
REQ-018 AR channel: o_arid, o_araddr, o_arlen, o_arsize, o_arburst and o_arvalid are outputs; i_arready is an input.
REQ-019 R channel: i_rid, i_rdata [64], i_rresp, i_rlast and i_rvalid are inputs; o_rready is an output.

Function
REQ-020 The block shall have at most one transaction outstanding.
REQ-021 The FSM shall have the states IDLE, WADDR, WRESP, RADDR, RDATA and RSP.
REQ-022 o_req_ready shall be 1 only in IDLE.
REQ-023 On acceptance, the request shall be registered and the FSM shall move to WADDR (we = 1) or RADDR (we = 0) on the next cycle.
REQ-024 In WADDR, o_awvalid and o_wvalid shall assert in the same cycle; each shall deassert independently after its own handshake; the FSM shall move to WRESP on the cycle both handshakes are complete, including when both complete in the same cycle.
REQ-025 o_awlen shall be 0, o_awburst and o_arburst shall be 1 (INCR), o_wlast shall be 1, and size shall be the registered i_req_size.
REQ-026 In WRESP, o_bready shall be 1; on i_bvalid, the FSM shall capture err = i_bresp[1] | (i_bid != TXN_ID) and move to RSP.
REQ-027 In RADDR, o_arvalid shall be 1; on i_arready, the FSM shall move to RDATA.
REQ-028 In RDATA, o_rready shall be 1; on i_rvalid, the FSM shall capture i_rdata and err = i_rresp[1] | (i_rid != TXN_ID) | !i_rlast, then move to RSP.
REQ-029 In RSP, o_rsp_valid shall be 1 and outputs shall be held stable until i_rsp_ready; on i_rsp_ready, the FSM shall return to IDLE.
REQ-030 Latency with zero-wait responders: accept to o_rsp_valid shall be 3 cycles for both reads and writes.
REQ-031 AXI valids shall never depend combinationally on the corresponding ready.
REQ-032 AXI payload shall be stable while the corresponding valid is high.
REQ-033 An i_bvalid or i_rvalid arriving outside WRESP/RDATA shall be ignored (ready is 0).
REQ-034 A write shall never issue AR; a read shall never issue AW or W.

Reset
REQ-035 When rst = 1, the FSM shall go to IDLE, and all valids, o_bready, o_rready, o_rsp_valid, o_rsp_err and o_rsp_rdata shall be 0 after the edge.
REQ-036 Reset asserted mid-transaction shall abandon the transaction without completing handshakes; the environment shall reset the responders in the same cycle.

Structure
REQ-037 The FSM state enum and the AXI constants (BURST_INCR = 2'b01, RESP_SLVERR = 2'b10) shall live in a shared package, axi_pkg.
REQ-038 The block shall be a single flat module with no sub-modules.

Verification
REQ-039 Write to 0x80000000 with wdata 0x1122334455667788, wstrb 0xFF, zero-wait responder -> one AW with awaddr 0x80000000 and awsize 3, one W with wlast 1, o_rsp_valid on the 3rd cycle, o_rsp_err 0.
REQ-040 Read from 0x00000010 with the responder returning 0xDEADBEEF00000000 after 5 wait cycles -> o_rsp_rdata 0xDEADBEEF00000000, o_rsp_err 0, no AW/W activity.
REQ-041 Write where i_wready is high 4 cycles before i_awready -> W accepted once, o_wvalid low afterward, FSM reaches WRESP only after the AW handshake.
REQ-042 Read answered with rresp 2'b10, then a second read answered with rid != TXN_ID -> o_rsp_err 1 in both cases.
REQ-043 Hold i_rsp_ready low for 10 cycles -> o_rsp_valid and data stable, o_req_ready 0 throughout, no new AXI traffic.
REQ-044 Assert rst in WADDR after the AW handshake but before the W handshake -> all valids 0 on the next cycle, o_req_ready 1, and a following read completes normally.
